// File: rtl/fpu_result_scheduler_pkg.sv
// fpu_result_scheduler_pkg: shared types and sizes for the FP result scheduler
package fpu_result_scheduler_pkg;
  localparam int FP_SCHED_SLOTS = 6;
  localparam int FP_UNITS = 4;
  localparam int FP_UNIT_W = $clog2(FP_UNITS);
  localparam int FP_CNT_W = $clog2(FP_SCHED_SLOTS + 1);
  typedef enum logic [FP_UNIT_W-1:0] {FPU_ADD, FPU_MUL, FPU_FMA, FPU_RSVD} fp_unit_id_e;
  typedef struct packed {
    logic valid;
    fp_unit_id_e unit;
    logic [4:0] dest;
  } fp_sched_slot_t;
endpackage

// File: rtl/fpu_result_scheduler_queue.sv
// fpu_sched_queue: wrap-around metadata FIFO with occupancy count
module fpu_sched_queue #(
  parameter int DEPTH = 6,
  parameter int W = 7,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (i_push) mem_d[wptr_q] = i_push_data;
    wptr_d = i_clr ? '0 : i_push ? inc(wptr_q) : wptr_q;
    rptr_d = i_clr ? '0 : i_pop ? inc(rptr_q) : rptr_q;
    cnt_d = i_clr ? '0 : cnt_q + CW'(i_push) - CW'(i_pop);
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge i_clk) mem_q <= mem_d;
  assign o_valid = cnt_q != '0;
  assign o_data = o_valid ? mem_q[rptr_q] : '0;
  assign o_count = cnt_q;
endmodule

// File: rtl/fpu_result_scheduler.sv
// fpu_result_scheduler: reservation table granting FP issue only into a free completion cycle
module fpu_result_scheduler
  import fpu_result_scheduler_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_issue_valid,
  input  logic [2:0]                i_issue_latency,
  input  logic [FP_UNIT_W-1:0]      i_issue_unit,
  input  logic [4:0]                i_issue_dest,
  output logic                      o_issue_ready,
  input  logic                      i_flush,
  output logic [FP_SCHED_SLOTS-1:0] o_inflight_valid,
  output logic [4:0]                o_inflight_dest_1,
  output logic [4:0]                o_inflight_dest_2,
  output logic [4:0]                o_inflight_dest_3,
  output logic [4:0]                o_inflight_dest_4,
  output logic [4:0]                o_inflight_dest_5,
  output logic [4:0]                o_inflight_dest_6,
  output logic                      o_complete_valid,
  output logic [FP_UNIT_W-1:0]      o_complete_unit,
  output logic                      o_wb_valid,
  output logic [FP_UNIT_W-1:0]      o_wb_unit,
  output logic [4:0]                o_wb_dest,
  input  logic                      i_wb_ready
);
  fp_sched_slot_t [FP_SCHED_SLOTS-1:0] slot_q, slot_d;
  logic [FP_CNT_W-1:0] inflight_cnt_q, inflight_cnt_d, queue_cnt;
  logic [FP_SCHED_SLOTS:0] occ;
  logic legal, fire, push, pop;
  logic [FP_UNIT_W+4:0] head;
  for (genvar j = 0; j < FP_SCHED_SLOTS; j++) begin : g_occ
    assign o_inflight_valid[j] = slot_q[j].valid;
  end
  // occ[NUM_SLOTS] stays empty so the longest latency never collides
  assign occ = {1'b0, o_inflight_valid};
  assign legal = i_issue_latency != 3'd0 && i_issue_latency <= 3'(FP_SCHED_SLOTS);
  assign o_issue_ready = legal && !occ[i_issue_latency] && !i_flush &&
                         ({1'b0, inflight_cnt_q} + {1'b0, queue_cnt}) < 4'(FP_SCHED_SLOTS);
  assign fire = i_issue_valid && o_issue_ready;
  assign push = slot_q[0].valid && !i_flush;
  assign pop = o_wb_valid && i_wb_ready;
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < FP_SCHED_SLOTS - 1; k++) slot_d[k] = slot_q[k+1];
    if (fire) slot_d[3'(i_issue_latency - 3'd1)] = {1'b1, i_issue_unit, i_issue_dest};
    if (i_flush) slot_d = '0;
    inflight_cnt_d = i_flush ? '0 :
                     inflight_cnt_q + FP_CNT_W'(fire) - FP_CNT_W'(slot_q[0].valid);
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      slot_q <= '0;
      inflight_cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      inflight_cnt_q <= inflight_cnt_d;
    end
  fpu_sched_queue #(.DEPTH(FP_SCHED_SLOTS), .W(FP_UNIT_W + 5)) u_queue (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_clr(i_flush),
    .i_push(push),
    .i_push_data({slot_q[0].unit, slot_q[0].dest}),
    .i_pop(pop),
    .o_valid(o_wb_valid),
    .o_data(head),
    .o_count(queue_cnt)
  );
  assign o_wb_unit = head[FP_UNIT_W+4:5];
  assign o_wb_dest = head[4:0];
  assign o_complete_valid = slot_q[0].valid;
  assign o_complete_unit = slot_q[0].unit;
  assign o_inflight_dest_1 = slot_q[0].dest;
  assign o_inflight_dest_2 = slot_q[1].dest;
  assign o_inflight_dest_3 = slot_q[2].dest;
  assign o_inflight_dest_4 = slot_q[3].dest;
  assign o_inflight_dest_5 = slot_q[4].dest;
  assign o_inflight_dest_6 = slot_q[5].dest;
  a_legal_latency: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_issue_valid |-> legal) else $error("illegal FP issue latency %0d", i_issue_latency);
  a_one_per_slot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    fire |-> !occ[i_issue_latency]);
  a_queue_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    queue_cnt <= FP_CNT_W'(FP_SCHED_SLOTS));
  a_wb_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_wb_valid && !i_wb_ready && !i_flush |=> $stable({o_wb_valid, o_wb_unit, o_wb_dest}));
endmodule

// File: tb/tb_fpu_result_scheduler.sv
// tb_fpu_result_scheduler: directed and random checks against a completion-time reference model
module tb_fpu_result_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, issue_valid = 1'b0, flush = 1'b0, wb_ready = 1'b0;
  logic [2:0] issue_latency = 3'd1;
  logic [1:0] issue_unit = 2'd0;
  logic [4:0] issue_dest = 5'd0;
  logic issue_ready, complete_valid, wb_valid;
  logic [5:0] inflight_valid;
  logic [4:0] d1, d2, d3, d4, d5, d6, wb_dest;
  logic [1:0] complete_unit, wb_unit;
  typedef struct {int tc; logic [1:0] u; logic [4:0] d;} op_t;
  typedef struct {logic [1:0] u; logic [4:0] d;} wb_t;
  op_t ops[$];
  wb_t wbq[$];
  int now = 0, vectors = 0, miscompares = 0;
  logic seen_ready, seen_cv, seen_wbv;
  logic [5:0] seen_iv;
  logic [4:0] seen_d3, seen_wbd;
  always #5 clk = ~clk;
  fpu_result_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid(issue_valid), .i_issue_latency(issue_latency),
    .i_issue_unit(issue_unit), .i_issue_dest(issue_dest), .o_issue_ready(issue_ready),
    .i_flush(flush), .o_inflight_valid(inflight_valid),
    .o_inflight_dest_1(d1), .o_inflight_dest_2(d2), .o_inflight_dest_3(d3),
    .o_inflight_dest_4(d4), .o_inflight_dest_5(d5), .o_inflight_dest_6(d6),
    .o_complete_valid(complete_valid), .o_complete_unit(complete_unit),
    .o_wb_valid(wb_valid), .o_wb_unit(wb_unit), .o_wb_dest(wb_dest), .i_wb_ready(wb_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // ops hold absolute completion cycles; slot k at cycle now is the op completing at now+k
  task automatic step(input logic v, input int lat, input logic [1:0] u, input logic [4:0] d,
                      input logic wbr, input logic fl);
    logic [5:0] ev;
    logic [29:0] ed;
    logic [2:0] ec;
    logic [7:0] ew;
    logic er, coll, fire;
    issue_valid = v; issue_latency = 3'(lat); issue_unit = u; issue_dest = d;
    wb_ready = wbr; flush = fl;
    @(negedge clk);
    ev = '0; ed = '0; ec = '0; coll = 1'b0;
    foreach (ops[i]) begin
      int r;
      r = ops[i].tc - now;
      ev[r] = 1'b1;
      ed[r*5 +: 5] = ops[i].d;
      if (r == 0) ec = {1'b1, ops[i].u};
      if (r == lat) coll = 1'b1;
    end
    er = lat >= 1 && lat <= 6 && !coll && (ops.size() + wbq.size()) < 6 && !fl;
    ew = wbq.size() > 0 ? {1'b1, wbq[0].u, wbq[0].d} : 8'd0;
    chk("issue_ready", 32'(issue_ready), 32'(er));
    chk("inflight_valid", 32'(inflight_valid), 32'(ev));
    chk("inflight_dest", 32'({d6, d5, d4, d3, d2, d1}), 32'(ed));
    chk("complete", 32'({complete_valid, complete_unit}), 32'(ec));
    chk("wb_head", 32'({wb_valid, wb_unit, wb_dest}), 32'(ew));
    seen_ready = issue_ready; seen_iv = inflight_valid; seen_d3 = d3;
    seen_cv = complete_valid; seen_wbv = wb_valid; seen_wbd = wb_dest;
    fire = v && er;
    @(posedge clk);
    if (wbq.size() > 0 && wbr) void'(wbq.pop_front());
    for (int i = ops.size() - 1; i >= 0; i--)
      if (ops[i].tc == now) begin
        if (!fl) wbq.push_back('{ops[i].u, ops[i].d});
        ops.delete(i);
      end
    if (fire) ops.push_back('{now + lat, u, d});
    if (fl) begin
      ops.delete();
      wbq.delete();
    end
    now++;
    #1;
  endtask
  task automatic idle(input int n, input logic wbr);
    repeat (n) step(1'b0, 1, 2'd0, 5'd0, wbr, 1'b0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; issue_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ops.delete();
    wbq.delete();
  endtask
  initial begin
    do_reset();
    idle(1, 1'b1);
    chk("rst_ready", 32'(seen_ready), 32'd1);
    chk("rst_inflight", 32'(seen_iv), 32'd0);
    chk("rst_wb_valid", 32'(seen_wbv), 32'd0);
    // single op, latency 3
    step(1'b1, 3, 2'd0, 5'd7, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("t1_dest3", 32'(seen_d3), 32'd7);
    idle(2, 1'b1);
    chk("t1_complete", 32'(seen_cv), 32'd1);
    chk("t1_no_bypass", 32'(seen_wbv), 32'd0);
    idle(1, 1'b1);
    chk("t1_wb_valid", 32'(seen_wbv), 32'd1);
    chk("t1_wb_dest", 32'(seen_wbd), 32'd7);
    idle(3, 1'b1);
    // completion-cycle collision
    step(1'b1, 4, 2'd1, 5'd2, 1'b1, 1'b0);
    step(1'b1, 3, 2'd1, 5'd3, 1'b1, 1'b0);
    chk("t2_collide", 32'(seen_ready), 32'd0);
    idle(6, 1'b1);
    step(1'b1, 4, 2'd1, 5'd2, 1'b1, 1'b0);
    step(1'b1, 2, 2'd2, 5'd4, 1'b1, 1'b0);
    chk("t2_no_collide", 32'(seen_ready), 32'd1);
    idle(6, 1'b1);
    // fill to capacity with the write port stalled, then drain
    for (int l = 1; l <= 6; l++) step(1'b1, l, 2'(l % 4), 5'(l), 1'b0, 1'b0);
    step(1'b1, 1, 2'd0, 5'd9, 1'b0, 1'b0);
    chk("t3_full", 32'(seen_ready), 32'd0);
    idle(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1, 2'd0, 5'd0, 1'b1, 1'b0);
      chk("t3_drain", 32'(seen_wbd), 32'(i + 1));
    end
    // push and pop together with the queue at five
    for (int l = 1; l <= 6; l++) step(1'b1, l, 2'(l % 4), 5'(20 + l), 1'b0, 1'b0);
    idle(5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1, 2'd0, 5'd0, 1'b1, 1'b0);
      chk("t4_order", 32'(seen_wbd), 32'(21 + i));
    end
    idle(2, 1'b1);
    // flush with three in flight and two queued
    step(1'b1, 1, 2'd0, 5'd10, 1'b0, 1'b0);
    step(1'b1, 1, 2'd1, 5'd11, 1'b0, 1'b0);
    step(1'b1, 6, 2'd2, 5'd12, 1'b0, 1'b0);
    step(1'b1, 6, 2'd2, 5'd13, 1'b0, 1'b0);
    step(1'b1, 6, 2'd3, 5'd14, 1'b0, 1'b0);
    step(1'b0, 1, 2'd0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 2, 2'd1, 5'd15, 1'b0, 1'b0);
    chk("t5_inflight", 32'(seen_iv), 32'd0);
    chk("t5_wb_valid", 32'(seen_wbv), 32'd0);
    chk("t5_ready", 32'(seen_ready), 32'd1);
    idle(4, 1'b1);
    // illegal latencies presented without valid
    step(1'b1, 5, 2'd1, 5'd16, 1'b1, 1'b0);
    step(1'b0, 0, 2'd0, 5'd17, 1'b1, 1'b0);
    chk("t6_lat0", 32'(seen_ready), 32'd0);
    step(1'b0, 7, 2'd0, 5'd18, 1'b1, 1'b0);
    chk("t6_lat7", 32'(seen_ready), 32'd0);
    idle(6, 1'b1);
    // reset in the middle of traffic
    step(1'b1, 2, 2'd0, 5'd19, 1'b0, 1'b0);
    step(1'b1, 5, 2'd1, 5'd20, 1'b0, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(1, 1'b1);
    chk("rst_mid_inflight", 32'(seen_iv), 32'd0);
    chk("rst_mid_wb", 32'(seen_wbv), 32'd0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      step(1'($urandom_range(0, 9) < 6), int'($urandom_range(1, 6)), 2'($urandom),
           5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end
    idle(10, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
